sha3_padder_l: RTL and testbench
================================

# sha3_padder_l

Input-side padder for the low-throughput SHA-3-512 core. Collects a message arriving as 64-bit words, applies multi-rate padding, and assembles 576-bit rate blocks (9 words). It presents each block to the downstream permutation stage on `in` / `in_ready` and holds the block until that stage pulses `ack`.

## Interface
- No parameters. Rate is fixed at 576 bits (9 words).
- `clk`  input  1  clock.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  64  message word. The first byte in message order is `in[63:56]`.
- `in_ready`  input  1  `in` is valid this cycle.
- `is_last`  input  1  current word is the final word of the message.
- `byte_num`  input  3  valid bytes in the final word (0..7). Meaningful only with `is_last`.
  - A full 8-byte final word is sent as a normal word, followed by `is_last` with `byte_num`=0.
- `buffer_full`  output  1  padder cannot accept input this cycle.
- `out`  output  576  assembled block. Word 0 sits at `out[575:512]`.
- `out_ready`  output  1  `out` holds a complete block.
- `f_ack`  input  1  downstream consumed the block. Connect to the permutation stage's `ack`.

## Operation
- State register with four states: ABSORB, PAD, FULL, DONE. A word index `cnt` runs 0..8.
- **ABSORB**
  - Accept occurs when `in_ready & ~buffer_full`.
  - On a non-last accept: write `in` to word slot `cnt`, then `cnt`++.
  - On a last accept: write the padded word to slot `cnt` and set the `last_seen` flag.
    - The padded word keeps bytes 0..`byte_num`-1 from `in`.
    - Byte `byte_num` is set to the domain byte.
    - All higher bytes are 0.
  - After a write to slot 8, go to FULL.
  - Otherwise, after the last word, go to PAD.
- **PAD**: write one all-zero word per cycle to slots `cnt`..8. `in_ready` is ignored. After slot 8 is written, go to FULL.
- **Final-byte rule**: when a block's slot-8 write comes from the last word or from PAD, OR 0x80 into `out[7:0]`.
  - If the domain byte falls in `out[7:0]` (last word at slot 8, `byte_num`=7), the byte becomes domain|0x80.
- **FULL**
  - `out_ready`=1 and `buffer_full`=1.
  - On `f_ack`, clear `cnt` to 0. Go to DONE if `last_seen`, else to ABSORB.
- **DONE**
  - `buffer_full`=1 and `out_ready`=0.
  - Input is ignored until reset. One message is processed per reset.
- `buffer_full` = 1 in PAD, FULL and DONE; 0 in ABSORB.
- Boundary conditions:
  - `in_ready` together with `f_ack` in FULL: the word is not accepted. Upstream must hold it.
  - `f_ack` outside FULL is ignored.
  - A last word with `byte_num`=0 at slot 0 produces a pure padding block.
- Reset at any point: state ABSORB, `cnt`=0, `last_seen`=0, `out`=0, `out_ready`=0, `buffer_full`=0. Any partial block is discarded.

## Timing
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- A word accepted at cycle t appears in `out` at t+1.
- Non-last block: `out_ready` rises the cycle after the 9th accept.
- Last word written to slot k: `out_ready` rises 9−k cycles after the accept. This is 1 cycle for k=8.
- `f_ack` at cycle t:
  - `out_ready` and `buffer_full` fall at t+1, unless the next state is DONE (then `buffer_full` stays 1).
  - The earliest next accept is at t+1.
- Throughput: at most one word per cycle, and one block per 9 + (permutation acknowledge latency) cycles.

## Configuration
- `SHA3_PAD_KECCAK_EN` defined: the domain byte is 0x01 (original Keccak padding).
- Not defined (default): the domain byte is 0x06 (FIPS-202 SHA-3 padding).
- Nothing else changes between the two builds.

## Structure
- Shared package `sha3_pkg` holds:
  - `RATE_WORDS`=9, `WORD_W`=64.
  - State enum {ABSORB, PAD, FULL, DONE}.
  - `PAD_DOMAIN` (selected by the macro) and `PAD_FINAL`=8'h80.
- Sub-module `sha3_pad_word`: combinational. Takes `in`[63:0] and `byte_num`; produces the masked word with the domain byte inserted. Instantiated once.

## Test plan
- **Full block**: reset, then 9 words 0x0101..0x0909 with no `is_last`.
  - `out_ready` one cycle after the 9th accept.
  - `out[575:512]`=0x0101 and `out[63:0]`=0x0909.
- **Empty message**: `is_last`, `byte_num`=0 at slot 0.
  - After 9 cycles, `out` = 0x06 in the top byte, 0x80 in `out[7:0]`, zeros elsewhere. Repeat with `SHA3_PAD_KECCAK_EN`: 0x01 in the top byte.
- **Merged pad byte**: 8 full words, then slot-8 word 0x1122334455667700 with `is_last`, `byte_num`=7.
  - `out[63:0]`=0x11223344556677**86**.
- **Multi-block**: 9 words, hold FULL for 5 cycles with `in_ready`=1, then `f_ack`.
  - No word lost. A second block accepted with `cnt` restarting at 0.
  - After the final block's `f_ack`, `buffer_full` stays 1 (DONE).
- **Reset mid-block**: 4 words accepted, then reset.
  - Next cycle: `out`=0, `out_ready`=0, `buffer_full`=0.
  - A fresh 9-word block assembles correctly.

Source files
------------

// File: rtl/sha3_pkg.sv
// sha3_pkg: shared widths, FSM states and pad bytes for the SHA-3 padder (SHA3_PAD_KECCAK_EN selects Keccak domain byte)
package sha3_pkg;
  localparam int RATE_WORDS = 9;
  localparam int WORD_W = 64;
  typedef enum logic [1:0] {ABSORB, PAD, FULL, DONE} state_t;
`ifdef SHA3_PAD_KECCAK_EN
  localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
  localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif
  localparam logic [7:0] PAD_FINAL = 8'h80;
endpackage

// File: rtl/sha3_pad_word.sv
// sha3_pad_word: keeps the first byte_num bytes of a final word and inserts the domain byte after them
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [2:0]        byte_num,
  output logic [WORD_W-1:0] out
);
  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign out[WORD_W-1-8*b -: 8] = byte_num > 3'(b) ? in[WORD_W-1-8*b -: 8] :
                                    byte_num == 3'(b) ? PAD_DOMAIN : 8'h00;
  end
endmodule

// File: rtl/sha3_padder_l.sv
// sha3_padder_l: collects 64-bit message words into padded 576-bit rate blocks, one message per reset
module sha3_padder_l
  import sha3_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_W-1:0]            in,
  input  logic                         in_ready,
  input  logic                         is_last,
  input  logic [2:0]                   byte_num,
  output logic                         buffer_full,
  output logic [RATE_WORDS*WORD_W-1:0] out,
  output logic                         out_ready,
  input  logic                         f_ack
);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last_seen, last_n, wr, fin;
  logic [WORD_W-1:0] pad_word, wr_base, wr_data;
  sha3_pad_word u_pad (.in(in), .byte_num(byte_num), .out(pad_word));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last_seen;
    wr = 1'b0;
    fin = 1'b0;
    wr_base = in;
    case (state)
      ABSORB: if (in_ready) begin
        wr = 1'b1;
        fin = is_last;
        wr_base = is_last ? pad_word : in;
        last_n = is_last;
        state_n = cnt == 4'd8 ? FULL : is_last ? PAD : ABSORB;
        cnt_n = cnt == 4'd8 ? cnt : cnt + 4'd1;
      end
      PAD: begin
        wr = 1'b1;
        fin = 1'b1;
        wr_base = '0;
        state_n = cnt == 4'd8 ? FULL : PAD;
        cnt_n = cnt == 4'd8 ? cnt : cnt + 4'd1;
      end
      FULL: if (f_ack) begin
        cnt_n = '0;
        state_n = last_seen ? DONE : ABSORB;
      end
      default: state_n = state;
    endcase
  end
  // The closing 0x80 only lands when the padded tail reaches the last slot of the block
  assign wr_data = {wr_base[WORD_W-1:8], wr_base[7:0] | (fin && cnt == 4'd8 ? PAD_FINAL : 8'h00)};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ABSORB;
      cnt <= '0;
      last_seen <= 1'b0;
      out <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last_seen <= last_n;
      for (int i = 0; i < RATE_WORDS; i++)
        if (wr && cnt == 4'(i)) out[RATE_WORDS*WORD_W-1-WORD_W*i -: WORD_W] <= wr_data;
    end
  end
  assign buffer_full = state != ABSORB;
  assign out_ready = state == FULL;
endmodule

// File: tb/tb_sha3_padder_l.sv
// tb_sha3_padder_l: table-driven and scoreboard bench for the SHA-3 padder
module tb_sha3_padder_l;
`ifdef SHA3_PAD_KECCAK_EN
  localparam logic [7:0] DOM = 8'h01;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif
  logic clk = 1'b0, reset = 1'b1, in_ready = 1'b0, is_last = 1'b0, f_ack = 1'b0;
  logic [63:0] in = '0;
  logic [2:0] byte_num = '0;
  logic buffer_full, out_ready;
  logic [575:0] out;
  int errors = 0, checks = 0;
  logic [575:0] exp_q[$];
  logic [63:0] m_words[9];
  int m_cnt = 0;
  logic prev_rdy = 1'b0;

  sha3_padder_l dut (.clk(clk), .reset(reset), .in(in), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .buffer_full(buffer_full), .out(out), .out_ready(out_ready), .f_ack(f_ack));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] tb_pad(input logic [63:0] d, input int bn);
    logic [63:0] mask;
    mask = bn == 0 ? 64'h0 : ~64'h0 << (64 - 8*bn);
    return (d & mask) | ({56'h0, DOM} << (56 - 8*bn));
  endfunction

  task automatic push_block();
    logic [575:0] b;
    for (int i = 0; i < 9; i++) b[575-64*i -: 64] = m_words[i];
    exp_q.push_back(b);
    m_cnt = 0;
  endtask

  task automatic model_accept(input logic [63:0] d, input logic last, input logic [2:0] bn);
    if (last) begin
      m_words[m_cnt] = tb_pad(d, int'(bn));
      for (int j = m_cnt + 1; j < 9; j++) m_words[j] = '0;
      m_words[8][7:0] = m_words[8][7:0] | 8'h80;
      push_block();
    end else begin
      m_words[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 9) push_block();
    end
  endtask

  always @(negedge clk) begin
    if (out_ready && !prev_rdy) begin
      if (exp_q.size() == 0) chk("sb_unexpected_block", 576'(out_ready), 576'(0));
      else chk("sb_block", out, exp_q.pop_front());
    end
    prev_rdy = out_ready;
  end

  task automatic do_reset();
    reset = 1'b1;
    in_ready = 1'b0;
    f_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_cnt = 0;
  endtask

  task automatic send(input logic [63:0] d, input logic last, input logic [2:0] bn);
    int n = 0;
    while (buffer_full && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_ready", 576'(buffer_full), 576'(0));
    in = d; is_last = last; byte_num = bn; in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0; is_last = 1'b0;
    model_accept(d, last, bn);
  endtask

  task automatic ack();
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [2:0]  bn;
    logic [63:0] data;
    logic [63:0] exp_k;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    vecs[0] = '{0, 3'd0, 64'hDEADBEEF_CAFEF00D, {DOM, 56'h0}, 9};
    vecs[1] = '{3, 3'd3, 64'hAABBCCDD_EEFF0011, {24'hAABBCC, DOM, 32'h0}, 6};
    vecs[2] = '{8, 3'd7, 64'h11223344_55667700, {56'h11223344556677, DOM | 8'h80}, 1};
    vecs[3] = '{8, 3'd0, 64'h12345678_9ABCDEF0, {DOM, 48'h0, 8'h80}, 1};
    vecs[4] = '{5, 3'd1, 64'hFE00_0000_0000_0011, {8'hFE, DOM, 48'h0}, 4};
    vecs[5] = '{7, 3'd7, 64'h01020304_05060708, {56'h01020304050607, DOM}, 2};

    do_reset();
    chk("reset_out", out, '0);
    chk("reset_out_ready", 576'(out_ready), 576'(0));
    chk("reset_buffer_full", 576'(buffer_full), 576'(0));

    foreach (vecs[v]) begin
      do_reset();
      for (int i = 0; i < vecs[v].k; i++) send(64'(i + 1) * 64'h0101, 1'b0, 3'd0);
      send(vecs[v].data, 1'b1, vecs[v].bn);
      lat = 1;
      while (!out_ready && lat < 20) begin @(posedge clk); #1; lat++; end
      chk($sformatf("vec%0d_latency", v), 576'(lat), 576'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_slot_k", v), 576'(out[575-64*vecs[v].k -: 64]), 576'(vecs[v].exp_k));
      ack();
      chk($sformatf("vec%0d_done_full", v), 576'(buffer_full), 576'(1));
      chk($sformatf("vec%0d_done_rdy", v), 576'(out_ready), 576'(0));
    end

    // full block, stall in FULL with a pending word, then a second, final block
    do_reset();
    for (int i = 0; i < 9; i++) send(64'(i + 1) * 64'h0101, 1'b0, 3'd0);
    chk("full_out_ready", 576'(out_ready), 576'(1));
    chk("full_word0", 576'(out[575:512]), 576'(64'h0101));
    chk("full_word8", 576'(out[63:0]), 576'(64'h0909));
    in = 64'hA5A5_0000_1111_2222; in_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_buffer_full", 576'(buffer_full), 576'(1));
      chk("hold_out_ready", 576'(out_ready), 576'(1));
    end
    f_ack = 1'b1;
    @(posedge clk); #1;
    f_ack = 1'b0;
    chk("ack_out_ready", 576'(out_ready), 576'(0));
    chk("ack_buffer_full", 576'(buffer_full), 576'(0));
    @(posedge clk); #1;
    in_ready = 1'b0;
    model_accept(64'hA5A5_0000_1111_2222, 1'b0, 3'd0);
    ack();
    send(64'h2222, 1'b0, 3'd0);
    send(64'h3333, 1'b0, 3'd0);
    send(64'h4455_6677_8899_AABB, 1'b1, 3'd2);
    for (int c = 0; c < 7; c++) begin @(posedge clk); #1; end
    chk("blk2_ready", 576'(out_ready), 576'(1));
    ack();
    chk("final_done_full", 576'(buffer_full), 576'(1));
    chk("final_done_rdy", 576'(out_ready), 576'(0));
    in_ready = 1'b1; in = 64'hFFFF;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; end
    in_ready = 1'b0;
    chk("done_ignores_input", 576'({buffer_full, out_ready}), 576'(2'b10));

    // reset in the middle of a block
    do_reset();
    for (int i = 0; i < 4; i++) send(64'hC0DE_0000 + 64'(i), 1'b0, 3'd0);
    do_reset();
    chk("midreset_out", out, '0);
    chk("midreset_out_ready", 576'(out_ready), 576'(0));
    chk("midreset_buffer_full", 576'(buffer_full), 576'(0));
    for (int i = 0; i < 9; i++) send(64'h5000_0000_0000_0000 + 64'(i * 3), 1'b0, 3'd0);
    chk("midreset_blk_ready", 576'(out_ready), 576'(1));

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_drain", 576'(exp_q.size()), 576'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
